// File: rtl/key_demux_router.sv
// key_demux_router: 1-to-NR_SLV request router decoding an address key field against a per-slave key table.
// Optional DEMUX_TIMEOUT_EN macro adds a FWD/WAIT timeout that returns an error response.
module key_demux_router #(
  parameter int NR_SLV  = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int KEY_LSB = 28,
  parameter int KEY_LEN = 4,
  parameter int TMO_CYC = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NR_SLV*KEY_LEN-1:0]  key_lut,
  input  logic                       m_req_valid,
  output logic                       m_req_ready,
  input  logic [ADDR_W-1:0]          m_addr,
  input  logic                       m_wen,
  input  logic [DATA_W-1:0]          m_wdata,
  input  logic [DATA_W/8-1:0]        m_wmask,
  output logic                       m_resp_valid,
  input  logic                       m_resp_ready,
  output logic [DATA_W-1:0]          m_rdata,
  output logic                       m_err,
  output logic [NR_SLV-1:0]          s_req_valid,
  input  logic [NR_SLV-1:0]          s_req_ready,
  output logic [ADDR_W-1:0]          s_addr,
  output logic                       s_wen,
  output logic [DATA_W-1:0]          s_wdata,
  output logic [DATA_W/8-1:0]        s_wmask,
  input  logic [NR_SLV-1:0]          s_resp_valid,
  output logic [NR_SLV-1:0]          s_resp_ready,
  input  logic [NR_SLV*DATA_W-1:0]   s_rdata
);

  localparam int SEL_W  = (NR_SLV > 1) ? $clog2(NR_SLV) : 1;
  localparam int MASK_W = DATA_W / 8;

  if (TMO_CYC < 1 || KEY_LSB + KEY_LEN > ADDR_W) begin : g_bad_cfg
    $error("key_demux_router: key field outside address or TMO_CYC < 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_FWD,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [ADDR_W-1:0]   r_addr;
  logic                r_wen;
  logic [DATA_W-1:0]   r_wdata;
  logic [MASK_W-1:0]   r_wmask;
  logic [SEL_W-1:0]    r_sel;
  logic                r_err;
  logic [DATA_W-1:0]   r_rdata;

  logic [KEY_LEN-1:0]  w_key;
  logic                w_hit;
  logic [SEL_W-1:0]    w_dec_sel;
  logic [NR_SLV-1:0]   w_sel_oh;
  logic [DATA_W-1:0]   w_slv_rdata;
  logic                w_accept;
  logic                w_req_hs;
  logic                w_resp_hs;
  logic                w_tmo;

  assign w_key = m_addr[KEY_LSB +: KEY_LEN];

  // Scanning downwards lets the lowest matching index overwrite any higher match.
  always_comb begin
    w_hit     = 1'b0;
    w_dec_sel = '0;
    for (int n = NR_SLV - 1; n >= 0; n--) begin
      if (key_lut[n*KEY_LEN +: KEY_LEN] == w_key) begin
        w_hit     = 1'b1;
        w_dec_sel = SEL_W'(n);
      end
    end
  end

  assign w_sel_oh    = NR_SLV'(1) << r_sel;
  assign w_slv_rdata = s_rdata[r_sel*DATA_W +: DATA_W];
  assign w_accept    = (r_state == S_IDLE) && m_req_valid;
  assign w_req_hs    = (r_state == S_FWD)  && !w_tmo && |(s_req_ready  & w_sel_oh);
  assign w_resp_hs   = (r_state == S_WAIT) && !w_tmo && |(s_resp_valid & w_sel_oh);

`ifdef DEMUX_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TMO_CYC + 1) > 8) ? $clog2(TMO_CYC + 1) : 8;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (r_state == S_FWD || r_state == S_WAIT) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Fires in the last FWD/WAIT cycle so RESP starts exactly TMO_CYC cycles after FWD entry.
  assign w_tmo = (r_state == S_FWD || r_state == S_WAIT) && (r_cnt == CNT_W'(TMO_CYC - 1));
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    m_req_ready  = 1'b0;
    m_resp_valid = 1'b0;
    m_rdata      = '0;
    m_err        = 1'b0;
    s_req_valid  = '0;
    s_resp_ready = '0;
    unique case (r_state)
      S_IDLE: begin
        m_req_ready = 1'b1;
        if (m_req_valid) begin
          w_next = w_hit ? S_FWD : S_RESP;
        end
      end
      S_FWD: begin
        if (!w_tmo) begin
          s_req_valid = w_sel_oh;
        end
        if (w_tmo) begin
          w_next = S_RESP;
        end else if (w_req_hs) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!w_tmo) begin
          s_resp_ready = w_sel_oh;
        end
        if (w_tmo || w_resp_hs) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        m_resp_valid = 1'b1;
        m_rdata      = r_rdata;
        m_err        = r_err;
        if (m_resp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_sel   <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= m_addr;
        r_wen   <= m_wen;
        r_wdata <= m_wdata;
        r_wmask <= m_wmask;
        r_sel   <= w_dec_sel;
        r_err   <= !w_hit;
        r_rdata <= '0;
      end
      if (w_resp_hs) begin
        r_rdata <= w_slv_rdata;
      end
      if (w_tmo) begin
        r_err   <= 1'b1;
        r_rdata <= '0;
      end
    end
  end

  assign s_addr  = r_addr;
  assign s_wen   = r_wen;
  assign s_wdata = r_wdata;
  assign s_wmask = r_wmask;

endmodule

// File: tb/tb_key_demux_router.sv
// Self-checking bench for key_demux_router: directed cases plus randomized transactions against a reference decode.
// Define DEMUX_TIMEOUT_EN to add the timeout case (DUT built with TMO_CYC=16).
module tb_key_demux_router;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int KL = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR*KL-1:0]  key_lut = '0;
  logic              m_req_valid = 1'b0;
  logic              m_req_ready;
  logic [AW-1:0]     m_addr = '0;
  logic              m_wen = 1'b0;
  logic [DW-1:0]     m_wdata = '0;
  logic [DW/8-1:0]   m_wmask = '0;
  logic              m_resp_valid;
  logic              m_resp_ready = 1'b0;
  logic [DW-1:0]     m_rdata;
  logic              m_err;
  logic [NR-1:0]     s_req_valid;
  logic [NR-1:0]     s_req_ready = '0;
  logic [AW-1:0]     s_addr;
  logic              s_wen;
  logic [DW-1:0]     s_wdata;
  logic [DW/8-1:0]   s_wmask;
  logic [NR-1:0]     s_resp_valid = '0;
  logic [NR-1:0]     s_resp_ready;
  logic [NR*DW-1:0]  s_rdata = '0;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  key_demux_router #(
    .NR_SLV (NR),
    .ADDR_W (AW),
    .DATA_W (DW),
    .KEY_LSB(28),
    .KEY_LEN(KL),
    .TMO_CYC(16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_lut     (key_lut),
    .m_req_valid (m_req_valid),
    .m_req_ready (m_req_ready),
    .m_addr      (m_addr),
    .m_wen       (m_wen),
    .m_wdata     (m_wdata),
    .m_wmask     (m_wmask),
    .m_resp_valid(m_resp_valid),
    .m_resp_ready(m_resp_ready),
    .m_rdata     (m_rdata),
    .m_err       (m_err),
    .s_req_valid (s_req_valid),
    .s_req_ready (s_req_ready),
    .s_addr      (s_addr),
    .s_wen       (s_wen),
    .s_wdata     (s_wdata),
    .s_wmask     (s_wmask),
    .s_resp_valid(s_resp_valid),
    .s_resp_ready(s_resp_ready),
    .s_rdata     (s_rdata)
  );

  task automatic chk(input string tag, input string what, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s.%s: observed %0h expected %0h", tag, what, obs, exp);
    end
  endtask

  // Reference decode: first table entry (lowest slave) whose key equals addr[31:28], else -1.
  function automatic int ref_sel(input logic [NR*KL-1:0] lut, input logic [AW-1:0] addr);
    logic [3:0] key;
    key = addr[31:28];
    for (int n = 0; n < NR; n++) begin
      if (lut[n*KL +: KL] == key) return n;
    end
    return -1;
  endfunction

  task automatic rand_rdata();
    for (int k = 0; k < NR*DW/32; k++) s_rdata[k*32 +: 32] = $urandom();
  endtask

  // One full transaction; every step happens on a falling edge so outputs are sampled away from posedge.
  task automatic txn(input string tag, input logic [AW-1:0] addr, input logic wen,
                     input logic [DW-1:0] wd, input logic [DW/8-1:0] wm, input logic [DW-1:0] rd,
                     input int req_wait, input int resp_wait, input int mr_wait, input logic [NR-1:0] stray);
    int            sel;
    logic [NR-1:0] oh;
    logic [DW-1:0] exp_rd;
    logic          exp_err;
    sel = ref_sel(key_lut, addr);
    oh  = (sel >= 0) ? (4'b0001 << sel) : 4'b0000;
    chk(tag, "idle_ready", 64'(m_req_ready), 64'd1);
    m_req_valid = 1'b1;
    m_addr = addr; m_wen = wen; m_wdata = wd; m_wmask = wm;
    @(negedge clk);
    m_req_valid = 1'b0;
    m_addr = $urandom(); m_wen = ~wen; m_wdata = {$urandom(), $urandom()}; m_wmask = ~wm;
    if (sel >= 0) begin
      for (int i = 0; i <= req_wait; i++) begin
        chk(tag, "s_req_valid", 64'(s_req_valid), 64'(oh));
        chk(tag, "s_addr", 64'(s_addr), 64'(addr));
        chk(tag, "s_wen", 64'(s_wen), 64'(wen));
        chk(tag, "s_wdata", s_wdata, wd);
        chk(tag, "s_wmask", 64'(s_wmask), 64'(wm));
        chk(tag, "fwd_resp_valid", 64'(m_resp_valid), 64'd0);
        chk(tag, "fwd_req_ready", 64'(m_req_ready), 64'd0);
        s_req_ready = (i == req_wait) ? oh : (4'($urandom_range(0, 15)) & ~oh);
        @(negedge clk);
      end
      s_req_ready = '0;
      for (int i = 0; i <= resp_wait; i++) begin
        chk(tag, "s_resp_ready", 64'(s_resp_ready), 64'(oh));
        chk(tag, "wait_req_valid", 64'(s_req_valid), 64'd0);
        chk(tag, "wait_resp_valid", 64'(m_resp_valid), 64'd0);
        rand_rdata();
        if (i == resp_wait) begin
          s_resp_valid = oh | (stray & ~oh);
          s_rdata[sel*DW +: DW] = rd;
        end else begin
          s_resp_valid = stray & ~oh;
        end
        @(negedge clk);
      end
      s_resp_valid = '0;
      rand_rdata();
      exp_rd  = rd;
      exp_err = 1'b0;
    end else begin
      exp_rd  = '0;
      exp_err = 1'b1;
    end
    for (int i = 0; i <= mr_wait; i++) begin
      chk(tag, "m_resp_valid", 64'(m_resp_valid), 64'd1);
      chk(tag, "m_err", 64'(m_err), 64'(exp_err));
      if (!wen || exp_err) chk(tag, "m_rdata", m_rdata, exp_rd);
      chk(tag, "resp_s_req_valid", 64'(s_req_valid), 64'd0);
      chk(tag, "resp_s_resp_ready", 64'(s_resp_ready), 64'd0);
      chk(tag, "resp_req_ready", 64'(m_req_ready), 64'd0);
      m_resp_ready = (i == mr_wait);
      @(negedge clk);
    end
    m_resp_ready = 1'b0;
    chk(tag, "done_resp_valid", 64'(m_resp_valid), 64'd0);
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [DW-1:0] rd_v;

    // Reset state
    #1;
    chk("rst", "m_req_ready", 64'(m_req_ready), 64'd1);
    chk("rst", "m_resp_valid", 64'(m_resp_valid), 64'd0);
    chk("rst", "s_req_valid", 64'(s_req_valid), 64'd0);
    chk("rst", "s_resp_ready", 64'(s_resp_ready), 64'd0);
    chk("rst", "s_addr", 64'(s_addr), 64'd0);
    chk("rst", "m_err", 64'(m_err), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // T2 read hit, zero-wait: response at cycle 3
    key_lut = {4'd3, 4'd2, 4'd1, 4'd0};
    txn("t2", 32'h2000_0010, 1'b0, 64'h0, 8'h00, 64'h0000_0000_DEAD_BEEF, 0, 0, 0, 4'b0000);

    // T3 miss: response at cycle 1 with error
    txn("t3", 32'h9000_0000, 1'b0, 64'h0, 8'h00, 64'h1234, 0, 0, 0, 4'b0000);

    // T4 backpressure on slave 1 and master
    txn("t4", 32'h1000_0A08, 1'b1, 64'hCAFE_F00D_0123_4567, 8'hF0, 64'h5555_AAAA_5555_AAAA, 5, 1, 3, 4'b0000);
    txn("t4r", 32'h1000_0A10, 1'b0, 64'h0, 8'h00, 64'h0BAD_C0DE_FACE_B00C, 5, 0, 3, 4'b0000);

    // T5 duplicate keys plus stray slave-3 responses during WAIT
    key_lut = 16'h1111;
    txn("t5", 32'h1ABC_0000, 1'b0, 64'h0, 8'h00, 64'h7777_6666_5555_4444, 0, 3, 0, 4'b1000);

    // T1 reset asserted mid-WAIT
    key_lut = {4'd3, 4'd2, 4'd1, 4'd0};
    m_req_valid = 1'b1; m_addr = 32'h1000_0040; m_wen = 1'b0;
    @(negedge clk);
    m_req_valid = 1'b0; s_req_ready = 4'b0010;
    @(negedge clk);
    s_req_ready = 4'b0000;
    chk("t1", "wait_resp_ready", 64'(s_resp_ready), 64'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("t1", "s_req_valid", 64'(s_req_valid), 64'd0);
    chk("t1", "s_resp_ready", 64'(s_resp_ready), 64'd0);
    chk("t1", "m_resp_valid", 64'(m_resp_valid), 64'd0);
    chk("t1", "s_addr", 64'(s_addr), 64'd0);
    @(negedge clk);
    s_resp_valid = 4'b0010;
    @(negedge clk);
    s_resp_valid = 4'b0000;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1", "post_req_ready", 64'(m_req_ready), 64'd1);
    chk("t1", "post_resp_valid", 64'(m_resp_valid), 64'd0);
    @(negedge clk);
    chk("t1", "post2_resp_valid", 64'(m_resp_valid), 64'd0);

    // Randomized transactions: small key range gives duplicates and misses
    for (int t = 0; t < 40; t++) begin
      for (int n = 0; n < NR; n++) key_lut[n*KL +: KL] = 4'($urandom_range(0, 7));
      ra   = {4'($urandom_range(0, 9)), 28'($urandom())};
      rd_v = {$urandom(), $urandom()};
      txn("rnd", ra, 1'($urandom_range(0, 1)), {$urandom(), $urandom()}, 8'($urandom()), rd_v,
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 4'($urandom()));
    end

`ifdef DEMUX_TIMEOUT_EN
    // T6 slave 0 accepts but never responds: error response 16 cycles after FWD entry
    key_lut = {4'd3, 4'd2, 4'd1, 4'd0};
    m_req_valid = 1'b1; m_addr = 32'h0000_0100; m_wen = 1'b0;
    @(negedge clk);
    m_req_valid = 1'b0;
    chk("t6", "s_req_valid", 64'(s_req_valid), 64'd1);
    s_req_ready = 4'b0001;
    for (int c = 1; c <= 16; c++) begin
      chk("t6", "early_resp_valid", 64'(m_resp_valid), 64'd0);
      @(negedge clk);
      s_req_ready = 4'b0000;
    end
    chk("t6", "tmo_resp_valid", 64'(m_resp_valid), 64'd1);
    chk("t6", "tmo_err", 64'(m_err), 64'd1);
    chk("t6", "tmo_rdata", m_rdata, 64'd0);
    chk("t6", "tmo_s_resp_ready", 64'(s_resp_ready), 64'd0);
    m_resp_ready = 1'b1;
    @(negedge clk);
    m_resp_ready = 1'b0;
    s_resp_valid = 4'b0001;
    s_rdata[DW-1:0] = 64'hFFFF_0000_FFFF_0000;
    @(negedge clk);
    s_resp_valid = 4'b0000;
    chk("t6", "late_req_ready", 64'(m_req_ready), 64'd1);
    chk("t6", "late_resp_valid", 64'(m_resp_valid), 64'd0);
    @(negedge clk);
    chk("t6", "late2_resp_valid", 64'(m_resp_valid), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
